// File: rtl/sal_timing_cntr_bank_if.sv
// rtl/sal_timing_cntr_bank_if.sv - load/status bundle for the DRAM timing counter bank
interface sal_timing_cntr_bank_if #(
  parameter int NUM_CNTR   = 8,
  parameter int CNTR_WIDTH = 6
);
  logic [NUM_CNTR-1:0]            load_vec_i;
  logic [NUM_CNTR*CNTR_WIDTH-1:0] load_val_i;
  logic                           load_all_i;
  logic [CNTR_WIDTH-1:0]          load_all_val_i;
  logic                           freeze_i;
  logic                           clr_i;
  logic [NUM_CNTR-1:0]            is_zero_o;
  logic [NUM_CNTR-1:0]            is_zero_n_o;
  logic                           all_zero_o;

  modport master (
    output load_vec_i, load_val_i, load_all_i, load_all_val_i, freeze_i, clr_i,
    input  is_zero_o, is_zero_n_o, all_zero_o
  );

  modport slave (
    input  load_vec_i, load_val_i, load_all_i, load_all_val_i, freeze_i, clr_i,
    output is_zero_o, is_zero_n_o, all_zero_o
  );
endinterface

// File: rtl/sal_timing_cntr_bank.sv
// rtl/sal_timing_cntr_bank.sv - bank of saturating down-counters enforcing DRAM timing constraints
// Optional SAL_TIMING_CNTR_BANK_MAXMERGE_EN: loads merge by max instead of overriding the count.
module sal_timing_cntr_bank #(
  parameter int NUM_CNTR   = 8,
  parameter int CNTR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sal_timing_cntr_bank_if.slave  bus
);

  logic [CNTR_WIDTH-1:0] cntr_q [NUM_CNTR];
  logic [CNTR_WIDTH-1:0] cntr_d [NUM_CNTR];
  logic [NUM_CNTR-1:0]   is_zero_q;
  logic [NUM_CNTR-1:0]   is_zero_d;
  logic                  all_zero_q;
  logic                  all_zero_d;

  logic [CNTR_WIDTH-1:0] dec_v;
  logic [CNTR_WIDTH-1:0] own_v;
  logic [CNTR_WIDTH-1:0] cand_v;

  always_comb begin
    dec_v  = '0;
    own_v  = '0;
    cand_v = '0;
    for (int k = 0; k < NUM_CNTR; k++) begin
      if (bus.freeze_i || (cntr_q[k] == '0)) begin
        dec_v = cntr_q[k];
      end else begin
        dec_v = cntr_q[k] - CNTR_WIDTH'(1);
      end
      own_v = bus.load_val_i[k*CNTR_WIDTH +: CNTR_WIDTH];
`ifdef SAL_TIMING_CNTR_BANK_MAXMERGE_EN
      // Loads only ever extend an outstanding constraint.
      cand_v = dec_v;
      if (bus.load_vec_i[k] && (own_v > cand_v)) begin
        cand_v = own_v;
      end
      if (bus.load_all_i && (bus.load_all_val_i > cand_v)) begin
        cand_v = bus.load_all_val_i;
      end
`else
      if (bus.load_vec_i[k]) begin
        cand_v = own_v;
      end else if (bus.load_all_i) begin
        cand_v = bus.load_all_val_i;
      end else begin
        cand_v = dec_v;
      end
`endif
      if (bus.clr_i) begin
        cand_v = '0;
      end
      cntr_d[k]    = cand_v;
      is_zero_d[k] = (cand_v == '0);
    end
    all_zero_d = &is_zero_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CNTR; k++) begin
        cntr_q[k] <= '0;
      end
      is_zero_q  <= '1;
      all_zero_q <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_CNTR; k++) begin
        cntr_q[k] <= cntr_d[k];
      end
      is_zero_q  <= is_zero_d;
      all_zero_q <= all_zero_d;
    end
  end

  assign bus.is_zero_o   = is_zero_q;
  assign bus.all_zero_o  = all_zero_q;
  // Counters read as zero throughout reset, whatever the load inputs are doing.
  assign bus.is_zero_n_o = rst_n ? is_zero_d : '1;

endmodule

// File: tb/tb_sal_timing_cntr_bank.sv
// tb/tb_sal_timing_cntr_bank.sv - directed self-checking bench for sal_timing_cntr_bank
module tb_sal_timing_cntr_bank;
  localparam int N = 8;
  localparam int W = 6;
`ifdef SAL_TIMING_CNTR_BANK_MAXMERGE_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  sal_timing_cntr_bank_if #(.NUM_CNTR(N), .CNTR_WIDTH(W)) bus ();

  sal_timing_cntr_bank #(.NUM_CNTR(N), .CNTR_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.load_vec_i     = '0;
    bus.load_val_i     = '0;
    bus.load_all_i     = 1'b0;
    bus.load_all_val_i = '0;
    bus.freeze_i       = 1'b0;
    bus.clr_i          = 1'b0;
  endtask

  task automatic load1(input int k, input int v);
    logic [W-1:0] vv;
    vv = v[W-1:0];
    bus.load_vec_i[k]          = 1'b1;
    bus.load_val_i[k*W +: W]   = vv;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_in();
    #2 rst_n = 1'b0;
    #1;
    check("rst_z",  bus.is_zero_o, 8'hFF);
    check("rst_az", bus.all_zero_o, 1);
    check("rst_zn", bus.is_zero_n_o, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
    check("idle_z",  bus.is_zero_o, 8'hFF);
    check("idle_az", bus.all_zero_o, 1);

    // Load counter 2 with 5 and watch it count out.
    load1(2, 5);
    #1 check("t1_zn_t0", bus.is_zero_n_o[2], 0);
    step(1);
    clear_in();
    for (int i = 1; i <= 6; i++) begin
      #1;
      check($sformatf("t1_z_%0d", i),  bus.is_zero_o[2],   (i == 6));
      check($sformatf("t1_zn_%0d", i), bus.is_zero_n_o[2], (i >= 5));
      if (i < 6) step(1);
    end
    check("t1_az", bus.all_zero_o, 1);

    // Counter 3 at 4, frozen for three cycles.
    clear_in();
    load1(3, 4);
    step(1);
    clear_in();
    bus.freeze_i = 1'b1;
    #1 check("t2_hold0", bus.is_zero_n_o[3], 0);
    step(1);
    check("t2_hold1", bus.is_zero_o[3], 0);
    step(1);
    check("t2_hold2", bus.is_zero_o[3], 0);
    step(1);
    bus.freeze_i = 1'b0;
    #1 check("t2_a3_zn", bus.is_zero_n_o[3], 0);
    step(3);
    check("t2_a6_z",  bus.is_zero_o[3], 0);
    check("t2_a6_zn", bus.is_zero_n_o[3], 1);
    step(1);
    check("t2_a7_z",  bus.is_zero_o[3], 1);

    // Load of 7 while frozen.
    bus.freeze_i = 1'b1;
    load1(3, 7);
    step(1);
    bus.load_vec_i = '0;
    check("t2f_b1", bus.is_zero_o[3], 0);
    step(1);
    bus.freeze_i = 1'b0;
    step(6);
    check("t2f_b8", bus.is_zero_o[3], 0);
    step(1);
    check("t2f_b9", bus.is_zero_o[3], 1);

    // Counter 1 at 6, reload with 2.
    clear_in();
    load1(1, 6);
    step(1);
    clear_in();
    load1(1, 2);
    step(1);
    clear_in();
    #1 check("t3_c2_z", bus.is_zero_o[1], 0);
    step(1);
    check("t3_c3_zn", bus.is_zero_n_o[1], MM ? 0 : 1);
    step(1);
    check("t3_c4_z", bus.is_zero_o[1], MM ? 0 : 1);
    step(2);
    check("t3_c6_z",  bus.is_zero_o[1], MM ? 0 : 1);
    check("t3_c6_zn", bus.is_zero_n_o[1], 1);
    step(1);
    check("t3_c7_z", bus.is_zero_o[1], 1);

    // Per-counter and broadcast load in the same cycle.
    load1(0, 3);
    bus.load_all_i     = 1'b1;
    bus.load_all_val_i = 6'd9;
    step(1);
    clear_in();
    check("t4_d1_az", bus.all_zero_o, 0);
    step(3);
    check("t4_d4_z", bus.is_zero_o, MM ? 8'h00 : 8'h01);
    step(5);
    check("t4_d9_z",  bus.is_zero_o, MM ? 8'h00 : 8'h01);
    check("t4_d9_zn", bus.is_zero_n_o, 8'hFF);
    step(1);
    check("t4_d10_z",  bus.is_zero_o, 8'hFF);
    check("t4_d10_az", bus.all_zero_o, 1);

    // Clear beats broadcast load, per-counter loads and freeze.
    bus.load_all_i     = 1'b1;
    bus.load_all_val_i = 6'd20;
    step(1);
    clear_in();
    check("t5_pre_z",  bus.is_zero_o, 8'h00);
    check("t5_pre_az", bus.all_zero_o, 0);
    bus.load_all_i     = 1'b1;
    bus.load_all_val_i = 6'd10;
    bus.load_vec_i     = '1;
    bus.load_val_i     = {N{6'd30}};
    bus.freeze_i       = 1'b1;
    bus.clr_i          = 1'b1;
    #1 check("t5_zn", bus.is_zero_n_o, 8'hFF);
    step(1);
    clear_in();
    check("t5_z",  bus.is_zero_o, 8'hFF);
    check("t5_az", bus.all_zero_o, 1);
    step(1);
    check("t5_z2", bus.is_zero_o, 8'hFF);

    // Maximum count 63 on counter 7, and a zero-value load on counter 5.
    load1(7, 63);
    load1(5, 0);
    #1 check("t6_zn5", bus.is_zero_n_o[5], 1);
    step(1);
    clear_in();
    check("t6_z5", bus.is_zero_o[5], 1);
    step(62);
    check("t6_z7_63",  bus.is_zero_o[7], 0);
    check("t6_zn7_63", bus.is_zero_n_o[7], 1);
    step(1);
    check("t6_z7_64", bus.is_zero_o[7], 1);

    // Asynchronous reset mid-cycle with counter 4 at 12.
    load1(4, 12);
    step(1);
    clear_in();
    #1 check("t7_pre", bus.is_zero_o[4], 0);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_z",  bus.is_zero_o, 8'hFF);
    check("t7_rst_az", bus.all_zero_o, 1);
    check("t7_rst_zn", bus.is_zero_n_o, 8'hFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    check("t7_post_z",  bus.is_zero_o, 8'hFF);
    check("t7_post_zn", bus.is_zero_n_o, 8'hFF);
    load1(4, 1);
    step(1);
    clear_in();
    check("t7_ld_z", bus.is_zero_o, 8'hEF);
    step(1);
    check("t7_ld_z2", bus.is_zero_o, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sal_timing_cntr_bank.md
Name: sal_timing_cntr_bank

Overview:
- Bank of NUM_CNTR independent saturating down-counters that enforce DRAM timing constraints (tRCD, tRP, tRAS, tWR, ...) for one channel's scheduler.
- Each counter is reloaded by a command event and decrements once per cycle to 0, never below.
- Generalises the single timing counter with:
  - multi-counter packing;
  - broadcast load;
  - max-merge of overlapping constraints;
  - global freeze and synchronous clear;
  - an early (next-cycle) zero flag.

Parameters:
- NUM_CNTR, 8, number of independent counters (1..32).
- CNTR_WIDTH, 6, width of each counter; max timing value 2^CNTR_WIDTH-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- load_vec_i  input  NUM_CNTR  per-counter load strobe.
- load_val_i  input  NUM_CNTR*CNTR_WIDTH  per-counter load value; counter k uses bits [k*CNTR_WIDTH +: CNTR_WIDTH].
- load_all_i  input  1  broadcast load strobe to every counter.
- load_all_val_i  input  CNTR_WIDTH  broadcast load value.
- freeze_i  input  1  suspends decrement of all counters (loads still apply).
- clr_i  input  1  synchronous clear of all counters to 0.
- is_zero_o  output  NUM_CNTR  registered: counter k == 0 this cycle.
- is_zero_n_o  output  NUM_CNTR  combinational: counter k will be 0 next cycle.
- all_zero_o  output  1  registered AND of is_zero_o.

Behaviour:
- Reset: rst_n low asynchronously forces every counter to 0.
  - is_zero_o = all 1s, all_zero_o = 1, is_zero_n_o = all 1s while rst_n is low.
- Per counter k, next value cntr_n[k] is evaluated in priority order:
  1. clr_i=1 -> 0, regardless of loads or freeze.
  2. dec = cntr[k] if freeze_i=1 or cntr[k]==0; otherwise cntr[k]-1. Never wraps below 0.
  3. cand = dec, merged with the per-counter load (if load_vec_i[k]) and the broadcast load (if load_all_i) per the merge rule under Optional Feature.
  4. cntr_n[k] = cand.
- Timing: load value V applied in cycle t gives cntr=V at t+1.
  - is_zero_o asserts at t+1+V with no freeze, no further loads and no clear.
  - V=0 load: counter is 0 at t+1 (no stall).
- is_zero_n_o[k] = (cntr_n[k]==0). It is purely combinational from the inputs. Consumers must not feed it back into the same-cycle load logic.
- all_zero_o is registered alongside the counters; it equals the AND of is_zero_o every cycle.
- Freeze: the counter value is held exactly. A freeze on a zero counter keeps it at 0.
- Clear: takes effect at the next edge. is_zero_o and all_zero_o are all 1 the following cycle.
- Max count 2^CNTR_WIDTH-1 loads and decrements normally; no overflow is possible because loads never add.
- Counters are fully independent. No cross-counter interaction except the broadcast load, freeze and clear.

Optional Feature:
- Macro: SAL_TIMING_CNTR_BANK_MAXMERGE_EN.
- Defined: cand = max(dec, per-counter value if loaded, broadcast value if loaded). A load never shortens an outstanding constraint.
- Undefined: loads override dec.
  - Per-counter load wins over broadcast when both are asserted.
  - Broadcast is applied when only load_all_i is asserted.
  - A smaller value can therefore shorten the constraint (legacy overwrite behaviour).
- Ports and latency are identical in both builds.

Test Plan:
- Reset then idle -> is_zero_o=8'hFF, all_zero_o=1. Load counter 2 with 5 at t=0 -> cntr2 = 5,4,3,2,1,0 over t+1..t+6. is_zero_o[2] low t+1..t+5, high at t+6. is_zero_n_o[2] high in cycle t+5.
- Counter 3 at value 4, freeze_i high 3 cycles, then low -> holds 4 for 3 cycles, then 3,2,1,0. A load of 7 during freeze -> 7 next cycle.
- Counter 1 at value 6, load 2 into it:
  - MAXMERGE_EN build -> next value 5.
  - Non-MAXMERGE build -> next value 2.
- Same cycle: load_vec_i[0]=1 with 3, load_all_i=1 with 9:
  - MAXMERGE_EN -> cntr0=9, others 9.
  - Non-MAXMERGE -> cntr0=3, others 9.
- All counters nonzero, clr_i=1 coincident with load_all_i (val 10) -> all counters 0 next cycle, all_zero_o=1.
- Counter 4 at value 12, rst_n pulsed low mid-cycle -> is_zero_o[4]=1 immediately (asynchronous). Counter stays 0 after rst_n deasserts until the next load.
